// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer that drives the CPU external-interrupt line.
// Define TIMER_PRESCALE_EN to add the 8-bit PRESC register at offset 3.
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] RESET_TH  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWr,
  input  logic        MemRd,
  output logic [31:0] rdata,
  input  logic        kernel_mode,
  output logic        IRQ
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_en;
  logic        r_ie;
  logic        r_stat;

  logic        w_hit;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_pre_tick;
  logic        w_tick;
  logic        w_tl_max;
  logic        w_ovf;
  logic [31:0] w_tcon;
  logic [31:0] w_off3;

  assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr_th   = MemWr & w_hit & (addr[3:2] == 2'd0);
  assign w_wr_tl   = MemWr & w_hit & (addr[3:2] == 2'd1);
  assign w_wr_tcon = MemWr & w_hit & (addr[3:2] == 2'd2);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] r_presc;
  logic [7:0] r_pcnt;
  logic       w_wr_presc;

  assign w_wr_presc = MemWr & w_hit & (addr[3:2] == 2'd3);
  assign w_pre_tick = (r_pcnt == r_presc);
  assign w_off3     = {24'h0, r_presc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= 8'h00;
    end else if (w_wr_presc) begin
      r_presc <= wdata[7:0];
    end
  end

  // pcnt restarts on any PRESC write so a new ratio takes effect cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= 8'h00;
    end else if (!r_en || w_wr_presc) begin
      r_pcnt <= 8'h00;
    end else if (w_pre_tick) begin
      r_pcnt <= 8'h00;
    end else begin
      r_pcnt <= r_pcnt + 8'd1;
    end
  end

  logic w_unused;
  assign w_unused = ^{addr[1:0], wdata[31:8]};
`else
  assign w_pre_tick = 1'b1;
  assign w_off3     = 32'h0;

  logic w_unused;
  assign w_unused = ^{addr[1:0], wdata[31:3]};
`endif

  assign w_tick   = r_en & w_pre_tick;
  assign w_tl_max = (r_tl == 32'hFFFF_FFFF);
  // A CPU write to TL suppresses both the increment and the overflow event.
  assign w_ovf    = w_tick & w_tl_max & ~w_wr_tl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th <= RESET_TH;
    end else if (w_wr_th) begin
      r_th <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tl <= 32'h0;
    end else if (w_wr_tl) begin
      r_tl <= wdata;
    end else if (w_tick) begin
      if (w_tl_max) begin
        r_tl <= r_th;
      end else begin
        r_tl <= r_tl + 32'd1;
      end
    end
  end

  // A hardware set of STAT beats a same-cycle software clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_ie   <= 1'b0;
      r_stat <= 1'b0;
    end else begin
      if (w_wr_tcon) begin
        r_en <= wdata[0];
        r_ie <= wdata[1];
      end
      r_stat <= (w_ovf & r_ie) | (w_wr_tcon ? wdata[2] : r_stat);
    end
  end

  assign w_tcon = {29'h0, r_stat, r_ie, r_en};

  always_comb begin
    rdata = 32'h0;
    if (MemRd && w_hit) begin
      case (addr[3:2])
        2'd0:    rdata = r_th;
        2'd1:    rdata = r_tl;
        2'd2:    rdata = w_tcon;
        default: rdata = w_off3;
      endcase
    end
  end

  assign IRQ = r_stat & r_ie & ~kernel_mode;

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed self-checking bench for timer_irq_source: register table plus
// hand-written overflow, mask, collision, prescale and reset sequences.
module tb_timer_irq_source;

  localparam logic [31:0] A_TH    = 32'h4000_0000;
  localparam logic [31:0] A_TL    = 32'h4000_0004;
  localparam logic [31:0] A_TCON  = 32'h4000_0008;
  localparam logic [31:0] A_PRESC = 32'h4000_000C;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWr;
  logic        MemRd;
  logic [31:0] rdata;
  logic        kernel_mode;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  timer_irq_source dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .MemWr       (MemWr),
    .MemRd       (MemRd),
    .rdata       (rdata),
    .kernel_mode (kernel_mode),
    .IRQ         (IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic        re;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    MemWr = 1'b1;
    @(posedge clk);
    #1;
    MemWr = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr  = a;
    MemRd = 1'b1;
    #1;
    chk(name, rdata, exp);
    MemRd = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_off3;
  logic [31:0] exp_off3_b;

  initial begin
`ifdef TIMER_PRESCALE_EN
    exp_off3   = 32'h0000_0055;
    exp_off3_b = 32'h0000_00FF;
`else
    exp_off3   = 32'h0;
    exp_off3_b = 32'h0;
`endif
    //          wr    waddr          wdat           re    raddr         exp_rd        irq
    vecs[0]  = '{1'b1, A_TH,          32'h1234_5678, 1'b1, A_TH,         32'h1234_5678, 1'b0};
    vecs[1]  = '{1'b1, A_TL,          32'hA5A5_0001, 1'b1, A_TL,         32'hA5A5_0001, 1'b0};
    vecs[2]  = '{1'b1, 32'h4000_0010, 32'h0000_DEAD, 1'b1, A_TH,         32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b1, 32'h3FFF_FFF4, 32'h0000_BEEF, 1'b1, A_TL,         32'hA5A5_0001, 1'b0};
    vecs[4]  = '{1'b1, A_TCON,        32'hFFFF_FFF8, 1'b1, A_TCON,       32'h0,         1'b0};
    vecs[5]  = '{1'b1, A_TCON,        32'h0000_0004, 1'b1, A_TCON,       32'h4,         1'b0};
    vecs[6]  = '{1'b1, A_TCON,        32'h0000_0006, 1'b1, A_TCON,       32'h6,         1'b1};
    vecs[7]  = '{1'b1, A_TCON,        32'h0000_0000, 1'b1, A_TCON,       32'h0,         1'b0};
    vecs[8]  = '{1'b0, A_TH,          32'h0,         1'b0, A_TH,         32'h0,         1'b0};
    vecs[9]  = '{1'b0, A_TH,          32'h0,         1'b1, 32'h4000_0014, 32'h0,        1'b0};
    vecs[10] = '{1'b1, A_PRESC,       32'h0000_0055, 1'b1, A_PRESC,      exp_off3,      1'b0};
    vecs[11] = '{1'b1, A_PRESC,       32'h0000_01FF, 1'b1, A_PRESC,      exp_off3_b,    1'b0};
    vecs[12] = '{1'b1, A_PRESC,       32'h0000_0000, 1'b1, A_PRESC,      32'h0,         1'b0};
    vecs[13] = '{1'b0, A_TH,          32'h0,         1'b1, A_TL,         32'hA5A5_0001, 1'b0};

    reset = 1'b1; addr = 32'h0; wdata = 32'h0;
    MemWr = 1'b0; MemRd = 1'b0; kernel_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    chk("rst_rdata_idle", rdata, 32'h0);
    chk_rd("rst_th_in_reset", A_TH, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_rd("rst_th", A_TH, 32'h0);
    chk_rd("rst_tl", A_TL, 32'h0);
    chk_rd("rst_tcon", A_TCON, 32'h0);
    step();
    chk_rd("rst_tl_hold", A_TL, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdat);
      else step();
      addr  = vecs[i].raddr;
      MemRd = vecs[i].re;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'h0, IRQ}, {31'h0, vecs[i].exp_irq});
      MemRd = 1'b0;
    end

    // Load and store together: read sees the old value.
    @(negedge clk);
    addr = A_TH; wdata = 32'hCAFE_0000; MemWr = 1'b1; MemRd = 1'b1;
    #1;
    chk("rdwr_old", rdata, 32'h1234_5678);
    @(posedge clk);
    #1;
    MemWr = 1'b0;
    chk("rdwr_new", rdata, 32'hCAFE_0000);
    MemRd = 1'b0;

    // Overflow and reload to TH.
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFD);
    wr(A_TCON, 32'h3);
    chk_rd("ovf_tl0", A_TL, 32'hFFFF_FFFD);
    step();
    chk_rd("ovf_tl1", A_TL, 32'hFFFF_FFFE);
    chk("ovf_irq_pre", {31'h0, IRQ}, 32'h0);
    step();
    chk_rd("ovf_tl2", A_TL, 32'hFFFF_FFFF);
    chk_rd("ovf_tcon_pre", A_TCON, 32'h3);
    step();
    chk_rd("ovf_reload", A_TL, 32'hFFFF_FFFD);
    chk_rd("ovf_tcon", A_TCON, 32'h7);
    chk("ovf_irq", {31'h0, IRQ}, 32'h1);
    kernel_mode = 1'b1;
    #1;
    chk("mask_irq", {31'h0, IRQ}, 32'h0);
    chk_rd("mask_tcon", A_TCON, 32'h7);
    kernel_mode = 1'b0;
    #1;
    chk("unmask_irq", {31'h0, IRQ}, 32'h1);
    wr(A_TCON, 32'h3);
    chk("clr_irq", {31'h0, IRQ}, 32'h0);
    chk_rd("clr_tcon", A_TCON, 32'h3);

    // Write-clear of TCON on the overflow cycle loses to the set.
    wr(A_TCON, 32'h0);
    wr(A_TH, 32'h0000_0100);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    step();
    chk_rd("col_tl_max", A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    chk_rd("col_tcon", A_TCON, 32'h7);
    chk_rd("col_tl_reload", A_TL, 32'h0000_0100);
    wr(A_TL, 32'h10);
    chk_rd("col_tl_wr", A_TL, 32'h10);
    step();
    chk_rd("col_tl_inc", A_TL, 32'h11);

    // TH write on the reload cycle: TL takes the old TH.
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h77);
    chk_rd("thcol_tl", A_TL, 32'h0000_0100);
    chk_rd("thcol_th", A_TH, 32'h77);

    // Overflow with IE=0, then freeze on EN 1->0.
    wr(A_TCON, 32'h0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h1);
    chk_rd("ie0_tl_pre", A_TL, 32'hFFFF_FFFF);
    step();
    chk_rd("ie0_tl", A_TL, 32'h77);
    chk_rd("ie0_tcon", A_TCON, 32'h1);
    chk("ie0_irq", {31'h0, IRQ}, 32'h0);
    wr(A_TCON, 32'h0);
    chk_rd("frz_tl0", A_TL, 32'h78);
    step();
    step();
    chk_rd("frz_tl1", A_TL, 32'h78);

`ifdef TIMER_PRESCALE_EN
    wr(A_TL, 32'h0);
    wr(A_PRESC, 32'h2);
    wr(A_TCON, 32'h1);
    step();
    step();
    chk_rd("pre_tl_c2", A_TL, 32'h0);
    step();
    chk_rd("pre_tl_c3", A_TL, 32'h1);
    step();
    step();
    chk_rd("pre_tl_c5", A_TL, 32'h1);
    step();
    chk_rd("pre_tl_c6", A_TL, 32'h2);
    chk_rd("pre_reg", A_PRESC, 32'h2);
`else
    wr(A_PRESC, 32'h2);
    chk_rd("off3_zero", A_PRESC, 32'h0);
`endif

    // Asynchronous reset in mid-cycle while counting with IRQ pending.
    wr(A_TH, 32'h55);
    wr(A_TL, 32'h5);
    wr(A_TCON, 32'h7);
    chk("prerst_irq", {31'h0, IRQ}, 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_irq", {31'h0, IRQ}, 32'h0);
    chk_rd("arst_th", A_TH, 32'h0);
    chk_rd("arst_tl", A_TL, 32'h0);
    chk_rd("arst_tcon", A_TCON, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    chk_rd("arst_tl_hold", A_TL, 32'h0);
    chk("arst_irq_hold", {31'h0, IRQ}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
